qei_speed: RTL and testbench
============================

Name: qei_speed

Overview:
Second-generation quadrature encoder interface for the motor/odometry path. Each encoder input is synchronised and glitch-filtered, then 4x decoded into a parametrised-width position counter. The block also counts illegal transitions and produces a signed per-period speed sample for the asservissement loop. An optional index input zeroes the position counter.

Parameters:
NBITS, 16, position counter width.
FILT_LEN, 3, consecutive identical synchronised samples required before a filtered input changes (>=1).
SPEED_BITS, 16, signed speed output width (<= NBITS).
PERIOD_BITS, 16, width of the speed sample period input.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
clr  in  1  synchronous clear: pos, speed, err_cnt, period counter, snapshot.
en  in  1  count enable.
in_A  in  1  encoder channel A (asynchronous pin).
in_B  in  1  encoder channel B (asynchronous pin).
in_I  in  1  encoder index (asynchronous pin; present only with QEI_INDEX_EN).
period  in  PERIOD_BITS  speed sample period in clk cycles; 0 disables sampling.
pos  out  NBITS  position count.
dir  out  1  direction of the last valid step (1 = up).
speed  out  SPEED_BITS  signed position delta over the last period.
speed_valid  out  1  one-cycle pulse when speed updates.
err_cnt  out  8  saturating count of illegal transitions.
index_seen  out  1  sticky flag set on an index event (present only with QEI_INDEX_EN).

Behaviour:
- Reset (rst_n low, asynchronous): every output is 0. Sync flops, filter state and the primed flag are also 0.
- Input path, per input: 2-FF synchroniser, then filter. The filtered value takes the synchronised value after FILT_LEN consecutive equal samples that differ from the current filtered value. A shorter pulse never propagates.
- Priming: after reset, the decoder stays idle until each filter has seen FILT_LEN stable samples. prev_AB is then loaded from the filtered AB with no count and no error. This prevents a spurious step or error when the pins are high at reset.
- Decode on (prev_AB, cur_AB), written as (A,B):
  - Up (+1): 00->10, 10->11, 11->01, 01->00.
  - Down (-1): the reverse of each up step.
  - Both bits changed: err_cnt increments and saturates at 255. pos is unchanged.
  - No change: hold.
- prev_AB updates every cycle regardless of en.
- en low: pos, dir and err_cnt hold.
- Latency: a clean pin edge changes pos exactly FILT_LEN+3 rising edges after the edge is first sampled.
- pos wraps modulo 2^NBITS in both directions. dir updates on every valid step.
- Speed:
  - The period counter runs 0..period-1. At period-1: speed <= pos - snap, snap <= pos, speed_valid pulses high for one cycle, and the counter returns to 0.
  - The difference is taken modulo 2^NBITS, interpreted as signed, then saturated to the SPEED_BITS signed range.
  - Both speed and snap use the registered (pre-update) pos, so a step in the sample cycle falls into the next window.
  - period == 0: counter held at 0 and no speed_valid pulse.
  - A period change takes effect on the next counter compare.
- clr: priority over en and the decode update; filter and sync state are preserved.
- Reset asserted mid-window: everything returns to reset state and no speed_valid pulse is issued.

Optional Feature:
QEI_INDEX_EN
- Defined:
  - in_I is filtered identically to A and B.
  - On a rising edge of filtered I with en high: pos <= 0, taking priority over a same-cycle step, and index_seen <= 1.
  - In that cycle snap <= snap - pos, so the speed window stays continuous across the zeroing.
  - index_seen is cleared only by clr or reset.
- Undefined: in_I and index_seen ports are absent and pos is never zeroed by the index.

Decomposition:
- Shared package qei_pkg:
  - step encodings (STEP_NONE, STEP_UP, STEP_DOWN, STEP_ERR);
  - ERR_CNT_BITS = 8;
  - default FILT_LEN and PERIOD_BITS constants.
- One sub-module, qei_filter: synchroniser plus FILT_LEN filter with a primed output. It is instantiated per input.

Test Plan:
- Reset with in_A=in_B=1, release, wait 10 cycles -> pos=0, err_cnt=0, no step.
- FILT_LEN=3, four forward quadrature steps held 8 cycles each -> pos=4, dir=1. First pos change exactly 6 edges after the first pin edge.
- 2-cycle glitch on in_A -> pos and err_cnt unchanged. 00->11 held stable -> err_cnt=1, pos unchanged. 300 such errors -> err_cnt=255.
- NBITS=16, pos=0, one reverse step -> pos=16'hFFFF. With period=100 and 5 reverse steps inside the window -> speed=-5, speed_valid high for exactly 1 cycle every 100 cycles.
- en=0 during 3 forward steps -> pos holds. clr during counting -> pos=0, speed=0, and the next window starts from the counter at 0.
- QEI_INDEX_EN, pos=50, snap=40, index edge plus 2 more forward steps before the sample -> pos=2, index_seen=1, speed=12.

Source files
------------

// File: rtl/qei_pkg.sv
// -----------------------------------------------------------------------------
// qei_pkg
// Shared definitions for the quadrature encoder interface:
//   - step_e        : decoded step between two consecutive filtered AB states
//   - ERR_CNT_BITS  : width of the saturating illegal-transition counter
//   - DEF_FILT_LEN  : default glitch-filter length
//   - DEF_PERIOD_BITS : default width of the speed period input
//   - qei_decode()  : 4x quadrature decode of (prev_ab, cur_ab), bit1 = A
// -----------------------------------------------------------------------------
package qei_pkg;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2,
    STEP_ERR  = 2'd3
  } step_e;

  localparam int ERR_CNT_BITS    = 8;
  localparam int DEF_FILT_LEN    = 3;
  localparam int DEF_PERIOD_BITS = 16;

  // Up sequence (A,B): 00 -> 10 -> 11 -> 01 -> 00. Any other single-bit
  // change is the reverse of one of these, so it is a down step.
  function automatic step_e qei_decode(input logic [1:0] prev_ab,
                                       input logic [1:0] cur_ab);
    step_e s;
    s = STEP_NONE;
    if ((prev_ab ^ cur_ab) == 2'b11) begin
      s = STEP_ERR;
    end else if (prev_ab != cur_ab) begin
      case ({prev_ab, cur_ab})
        4'b0010, 4'b1011, 4'b1101, 4'b0100: s = STEP_UP;
        default:                            s = STEP_DOWN;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/qei_filter.sv
// -----------------------------------------------------------------------------
// qei_filter
// Two-flop synchroniser followed by a run-length glitch filter for one
// asynchronous encoder pin.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   pin_i    : raw asynchronous pin
//   filt_o   : filtered level; follows the pin only after FILT_LEN
//              consecutive identical synchronised samples
//   primed_o : set once the filter has seen FILT_LEN stable samples; sticky
// -----------------------------------------------------------------------------
module qei_filter
  import qei_pkg::*;
#(
  parameter int FILT_LEN = DEF_FILT_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic filt_o,
  output logic primed_o
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic          sync1_q, sync2_q;
  logic [1:0]    warm_q;
  logic          last_q, last_d;
  logic [CW-1:0] run_q, run_d;
  logic          filt_q, filt_d;
  logic          primed_q, primed_d;

  // The first two synchroniser outputs after reset are the flops' reset
  // value, not the pin. warm_q holds the filter off until real samples
  // arrive so those zeros can never prime the filter.
  always_comb begin
    last_d   = last_q;
    run_d    = run_q;
    filt_d   = filt_q;
    primed_d = primed_q;
    if (warm_q[1]) begin
      last_d = sync2_q;
      if (run_q != '0 && sync2_q == last_q) begin
        if (run_q != CW'(FILT_LEN)) run_d = run_q + 1'b1;
      end else begin
        run_d = CW'(1);
      end
      if (run_d == CW'(FILT_LEN)) begin
        filt_d   = sync2_q;
        primed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      warm_q   <= 2'b00;
      last_q   <= 1'b0;
      run_q    <= '0;
      filt_q   <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      sync1_q  <= pin_i;
      sync2_q  <= sync1_q;
      warm_q   <= {warm_q[0], 1'b1};
      last_q   <= last_d;
      run_q    <= run_d;
      filt_q   <= filt_d;
      primed_q <= primed_d;
    end
  end

  assign filt_o   = filt_q;
  assign primed_o = primed_q;

endmodule

// File: rtl/qei_speed.sv
// -----------------------------------------------------------------------------
// qei_speed
// Quadrature encoder interface: filtered 4x decode into an NBITS position
// counter, saturating illegal-transition counter, and a signed per-period
// speed sample.
// Optional build macro: QEI_INDEX_EN adds the in_I / index_seen ports; a
// rising filtered index zeroes the position.
//   clk, rst_n    : clock, asynchronous active-low reset
//   clr           : synchronous clear of pos, speed, err_cnt, period counter,
//                   snapshot (and index_seen)
//   en            : count enable
//   in_A, in_B    : encoder channels (asynchronous)
//   in_I          : encoder index (asynchronous, QEI_INDEX_EN only)
//   period        : speed sample period in clk cycles, 0 = no sampling
//   pos, dir      : position count, direction of last valid step (1 = up)
//   speed         : signed position delta over the last period
//   speed_valid   : one-cycle pulse when speed updates
//   err_cnt       : saturating illegal-transition count
//   index_seen    : sticky index flag (QEI_INDEX_EN only)
// -----------------------------------------------------------------------------
module qei_speed
  import qei_pkg::*;
#(
  parameter int NBITS       = 16,
  parameter int FILT_LEN    = DEF_FILT_LEN,
  parameter int SPEED_BITS  = 16,
  parameter int PERIOD_BITS = DEF_PERIOD_BITS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         en,
  input  logic                         in_A,
  input  logic                         in_B,
`ifdef QEI_INDEX_EN
  input  logic                         in_I,
`endif
  input  logic [PERIOD_BITS-1:0]       period,
  output logic [NBITS-1:0]             pos,
  output logic                         dir,
  output logic signed [SPEED_BITS-1:0] speed,
  output logic                         speed_valid,
  output logic [ERR_CNT_BITS-1:0]      err_cnt
`ifdef QEI_INDEX_EN
  ,
  output logic                         index_seen
`endif
);

`ifdef QEI_INDEX_EN
  localparam int NIN = 3;
`else
  localparam int NIN = 2;
`endif

  logic [NIN-1:0] pins, filt, primed;

  assign pins[0] = in_A;
  assign pins[1] = in_B;
`ifdef QEI_INDEX_EN
  assign pins[2] = in_I;
`endif

  generate
    for (genvar gi = 0; gi < NIN; gi++) begin : g_filt
      qei_filter #(.FILT_LEN(FILT_LEN)) u_filt (
        .clk      (clk),
        .rst_n    (rst_n),
        .pin_i    (pins[gi]),
        .filt_o   (filt[gi]),
        .primed_o (primed[gi])
      );
    end
  endgenerate

  logic [1:0]               cur_ab, prev_ab_q;
  logic                     primed_q;
  step_e                    step;
  logic                     idx_rise;
  logic [NBITS-1:0]         pos_q, pos_d;
  logic                     dir_q, dir_d;
  logic [ERR_CNT_BITS-1:0]  err_q, err_d;
  logic [PERIOD_BITS-1:0]   cnt_q, cnt_d;
  logic [NBITS-1:0]         snap_q, snap_d;
  logic signed [SPEED_BITS-1:0] speed_q, speed_d;
  logic                     valid_q, valid_d;
  logic [NBITS-1:0]         diff;
  logic                     diff_fits;
  logic [SPEED_BITS-1:0]    diff_sat;

  assign cur_ab = {filt[0], filt[1]};

  // Decoding waits one cycle after every filter is primed; by then prev_ab
  // has tracked the filtered state, so pins high at reset give no step.
  assign step = primed_q ? qei_decode(prev_ab_q, cur_ab) : STEP_NONE;

`ifdef QEI_INDEX_EN
  logic prev_i_q;
  logic idx_seen_q, idx_seen_d;
  assign idx_rise   = primed_q & filt[2] & ~prev_i_q;
  assign index_seen = idx_seen_q;
`else
  assign idx_rise = 1'b0;
`endif

  // Position / direction / error counter.
  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    err_d = err_q;
`ifdef QEI_INDEX_EN
    idx_seen_d = idx_seen_q;
`endif
    if (clr) begin
      pos_d = '0;
      err_d = '0;
`ifdef QEI_INDEX_EN
      idx_seen_d = 1'b0;
`endif
    end else if (en) begin
      case (step)
        STEP_UP: begin
          pos_d = pos_q + 1'b1;
          dir_d = 1'b1;
        end
        STEP_DOWN: begin
          pos_d = pos_q - 1'b1;
          dir_d = 1'b0;
        end
        STEP_ERR: begin
          if (err_q != {ERR_CNT_BITS{1'b1}}) err_d = err_q + 1'b1;
        end
        default: ;
      endcase
      // Index zeroing overrides any step landing in the same cycle.
      if (idx_rise) pos_d = '0;
`ifdef QEI_INDEX_EN
      if (idx_rise) idx_seen_d = 1'b1;
`endif
    end
  end

  // Window delta, taken modulo 2^NBITS, then clamped to the signed
  // SPEED_BITS range: it fits when all bits above the output sign agree.
  assign diff      = pos_q - snap_q;
  assign diff_fits = (diff[NBITS-1:SPEED_BITS-1] == '0) ||
                     (diff[NBITS-1:SPEED_BITS-1] == '1);
  assign diff_sat  = diff_fits ? diff[SPEED_BITS-1:0] :
                     (diff[NBITS-1] ? {1'b1, {(SPEED_BITS-1){1'b0}}}
                                    : {1'b0, {(SPEED_BITS-1){1'b1}}});

  // Period counter and speed sample; uses the registered pos so a step
  // in the sample cycle is counted in the following window.
  always_comb begin
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    speed_d = speed_q;
    valid_d = 1'b0;
    if (clr) begin
      cnt_d   = '0;
      snap_d  = '0;
      speed_d = '0;
    end else begin
      if (period == '0) begin
        cnt_d = '0;
      end else if (cnt_q >= period - 1'b1) begin
        // >= rather than == so a shortened period cannot strand the counter.
        cnt_d   = '0;
        speed_d = diff_sat;
        snap_d  = pos_q;
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      // Shift the snapshot by the same amount the index removes from pos
      // so the current window still measures true travel.
      if (en && idx_rise) snap_d = snap_d - pos_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_ab_q <= 2'b00;
      primed_q  <= 1'b0;
      pos_q     <= '0;
      dir_q     <= 1'b0;
      err_q     <= '0;
      cnt_q     <= '0;
      snap_q    <= '0;
      speed_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      prev_ab_q <= cur_ab;
      primed_q  <= &primed;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      speed_q   <= speed_d;
      valid_q   <= valid_d;
    end
  end

`ifdef QEI_INDEX_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_i_q   <= 1'b0;
      idx_seen_q <= 1'b0;
    end else begin
      prev_i_q   <= filt[2];
      idx_seen_q <= idx_seen_d;
    end
  end
`endif

  assign pos         = pos_q;
  assign dir         = dir_q;
  assign err_cnt     = err_q;
  assign speed       = speed_q;
  assign speed_valid = valid_q;

endmodule

// File: tb/tb_qei_speed.sv
// -----------------------------------------------------------------------------
// tb_qei_speed
// Self-checking bench for qei_speed (default parameters). Expected speed
// samples are queued as windows are stimulated and compared when
// speed_valid pulses, together with the spacing between pulses.
// -----------------------------------------------------------------------------
module tb_qei_speed;

  logic               clk;
  logic               rst_n;
  logic               clr;
  logic               en;
  logic               in_A;
  logic               in_B;
  logic               in_I;
  logic [15:0]        period;
  logic [15:0]        pos;
  logic               dir;
  logic signed [15:0] speed;
  logic               speed_valid;
  logic [7:0]         err_cnt;
  logic               index_seen;

  qei_speed dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .en          (en),
    .in_A        (in_A),
    .in_B        (in_B),
`ifdef QEI_INDEX_EN
    .in_I        (in_I),
`endif
    .period      (period),
    .pos         (pos),
    .dir         (dir),
    .speed       (speed),
    .speed_valid (speed_valid),
    .err_cnt     (err_cnt)
`ifdef QEI_INDEX_EN
    ,
    .index_seen  (index_seen)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int    spd;
    int    gap;
    string tag;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          edge_cnt = 0;
  int          last_pulse = 0;
  int          clr_ref = 0;
  logic [1:0]  ab;
  logic [15:0] m_pos;
  logic [15:0] m_snap;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Pulse monitor: pop the scoreboard on every speed_valid.
  always @(negedge clk) begin
    if (rst_n && speed_valid) begin
      if (sb.size() == 0) begin
        chk("unexp_pulse", 1, 0);
      end else begin
        exp_t e;
        int   base;
        e = sb.pop_front();
        base = (clr_ref > last_pulse) ? clr_ref : last_pulse;
        $display("pulse %s: speed=%0d edge=%0d", e.tag, speed, edge_cnt);
        chk({e.tag, "_spd"}, speed, e.spd);
        if (e.gap != 0) chk({e.tag, "_gap"}, edge_cnt - base, e.gap);
      end
      last_pulse = edge_cnt;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [1:0] fwd_next(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev_next(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic step(input bit fwd, input int hold);
    ab   = fwd ? fwd_next(ab) : rev_next(ab);
    in_A = ab[1];
    in_B = ab[0];
    if (en) m_pos = fwd ? m_pos + 16'd1 : m_pos - 16'd1;
    cyc(hold);
  endtask

  task automatic push_win(input string tag, input int gap);
    exp_t e;
    e.spd = int'($signed(m_pos - m_snap));
    e.gap = gap;
    e.tag = tag;
    sb.push_back(e);
    m_snap = m_pos;
  endtask

  task automatic wait_sb(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      cyc(1);
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    clr_ref = edge_cnt + 1;
    cyc(1);
    clr = 1'b0;
    m_pos  = '0;
    m_snap = '0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; en = 1'b1; period = '0;
    in_A = 1'b1; in_B = 1'b1; in_I = 1'b0; ab = 2'b11;
    m_pos = '0; m_snap = '0;
    cyc(3);
    chk("rst_pos", pos, 0);
    chk("rst_dir", dir, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_speed", speed, 0);
    chk("rst_valid", speed_valid, 0);
`ifdef QEI_INDEX_EN
    chk("rst_idx", index_seen, 0);
`endif

    // Pins high at reset: priming must hide the 00 -> 11 change.
    rst_n = 1'b1;
    cyc(10);
    $display("prime: pos=%0d err=%0d", pos, err_cnt);
    chk("prime_pos", pos, 0);
    chk("prime_err", err_cnt, 0);

    // Latency: first forward step sampled at edge 1 moves pos on edge 6.
    ab = fwd_next(ab); in_A = ab[1]; in_B = ab[0]; m_pos = m_pos + 16'd1;
    cyc(5);
    chk("lat_before", pos, 0);
    cyc(1);
    chk("lat_at", pos, m_pos);
    cyc(2);
    for (int i = 0; i < 3; i++) step(1'b1, 8);
    $display("fwd4: pos=%0d dir=%0d", pos, dir);
    chk("fwd4_pos", pos, m_pos);
    chk("fwd4_dir", dir, 1);

    // Two-cycle glitch on A must not propagate.
    in_A = ~in_A; cyc(2); in_A = ~in_A; cyc(10);
    chk("glitch_pos", pos, m_pos);
    chk("glitch_err", err_cnt, 0);

    // Both bits change: one illegal transition.
    ab = ~ab; in_A = ab[1]; in_B = ab[0]; cyc(8);
    chk("err1_cnt", err_cnt, 1);
    chk("err1_pos", pos, m_pos);
    for (int i = 0; i < 300; i++) begin
      ab = ~ab; in_A = ab[1]; in_B = ab[0]; cyc(6);
    end
    $display("err301: err=%0d pos=%0d", err_cnt, pos);
    chk("errsat_cnt", err_cnt, 255);
    chk("errsat_pos", pos, m_pos);

    do_clr();
    chk("clr_pos", pos, 0);
    chk("clr_err", err_cnt, 0);

    // Reverse from zero wraps; then speed windows of 100 cycles.
    period = 16'd100;
    step(1'b0, 8);
    chk("wrap_pos", pos, 16'hFFFF);
    chk("wrap_dir", dir, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 8);
    push_win("win1", 0);
    push_win("win2", 100);
    en = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 8);
    chk("en_hold", pos, m_pos);
    en = 1'b1;
    push_win("win3", 100);
    wait_sb(400, "drain_win");

    // Clear mid-window restarts the counter from 0.
    step(1'b1, 8);
    do_clr();
    chk("clrw_pos", pos, 0);
    chk("clrw_speed", speed, 0);
    push_win("clr_win", 100);
    wait_sb(150, "drain_clr");

    period = '0;
    cyc(250);
    chk("p0_valid", speed_valid, 0);

`ifdef QEI_INDEX_EN
    do_clr();
    chk("idx_clr", index_seen, 0);
    period = 16'd400;
    for (int i = 0; i < 40; i++) step(1'b1, 8);
    push_win("idx_pre", 0);
    wait_sb(200, "drain_idx_pre");
    for (int i = 0; i < 10; i++) step(1'b1, 8);
    chk("idx_pos50", pos, m_pos);
    in_I = 1'b1; cyc(8); in_I = 1'b0; cyc(8);
    m_snap = m_snap - m_pos;
    m_pos  = '0;
    for (int i = 0; i < 2; i++) step(1'b1, 8);
    $display("index: pos=%0d seen=%0d", pos, index_seen);
    chk("idx_pos", pos, m_pos);
    chk("idx_seen", index_seen, 1);
    push_win("idx_win", 400);
    wait_sb(400, "drain_idx");
    do_clr();
    chk("idx_seen_clr", index_seen, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
